// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS definitions: sync header codes, lock FSM encoding and
// default block-lock thresholds.
package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int LOCK_CNT_DEF   = 64;
  localparam int WINDOW_CNT_DEF = 64;
  localparam int BAD_SH_MAX_DEF = 16;
  localparam int SLIP_WAIT_DEF  = 4;

  typedef enum logic [1:0] {
    LK_HUNT      = 2'd0,
    LK_SLIP_WAIT = 2'd1,
    LK_LOCKED    = 2'd2
  } lock_state_e;

  function automatic logic sh_valid(input logic [1:0] sh);
    return (sh == SYNC_DATA) || (sh == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/rx_block_lock_descrambler_if.sv
// Gearbox-to-decoder block bus: raw blocks in, slip/lock status and
// descrambled blocks out.
interface rx_block_lock_descrambler_if #(
  parameter int PCS_DATA_WIDTH = 64
);
  logic [PCS_DATA_WIDTH-1:0] in_block_data;
  logic [1:0]                in_block_header;
  logic                      in_block_valid;
  logic                      out_slip;
  logic                      out_block_lock;
  logic [PCS_DATA_WIDTH-1:0] out_encoded_data;
  logic [1:0]                out_encoded_header;
  logic                      out_encoded_valid;

  modport master (
    output in_block_data, in_block_header, in_block_valid,
    input  out_slip, out_block_lock, out_encoded_data, out_encoded_header, out_encoded_valid
  );

  modport slave (
    input  in_block_data, in_block_header, in_block_valid,
    output out_slip, out_block_lock, out_encoded_data, out_encoded_header, out_encoded_valid
  );
endinterface

// File: rtl/rx_descrambler_58.sv
// 64-bit parallel self-synchronising descrambler, x^58 + x^39 + 1.
// Output is combinational from the current state; state advances on en_i.
module rx_descrambler_58 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o
);

  logic [57:0]  state_q, state_d;
  logic [121:0] ext;

  // ext[57:0] holds the previous 58 line bits (ext[57] newest), ext[121:58] this block
  always_comb begin
    ext     = {data_i, state_q};
    data_o  = '0;
    for (int i = 0; i < 64; i++) begin
      data_o[i] = ext[58+i] ^ ext[19+i] ^ ext[i];
    end
    state_d = data_i[63:6];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
    end else if (en_i) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/rx_block_lock_descrambler.sv
// 10GBASE-R RX block lock (sync-header hunt with gearbox slip) and payload
// descrambling; blocks reach the decoder only while lock is held.
module rx_block_lock_descrambler
  import pcs_pkg::*;
#(
  parameter int PCS_DATA_WIDTH = 64,
  parameter int LOCK_CNT       = LOCK_CNT_DEF,
  parameter int WINDOW_CNT     = WINDOW_CNT_DEF,
  parameter int BAD_SH_MAX     = BAD_SH_MAX_DEF,
  parameter int SLIP_WAIT      = SLIP_WAIT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  rx_block_lock_descrambler_if.slave  bus
);

  localparam int SH_W = $clog2(LOCK_CNT + 1);
  localparam int WN_W = $clog2(WINDOW_CNT + 1);
  localparam int BD_W = $clog2(BAD_SH_MAX + 1);
  localparam int WT_W = $clog2(SLIP_WAIT + 1);

  lock_state_e               state_q;
  logic [SH_W-1:0]           sh_cnt_q;
  logic [WN_W-1:0]           win_cnt_q;
  logic [BD_W-1:0]           bad_cnt_q;
  logic [WT_W-1:0]           wait_cnt_q;
  logic                      slip_q;
  logic                      lock_q;
  logic                      out_vld_q;
  logic [PCS_DATA_WIDTH-1:0] out_data_q;
  logic [1:0]                out_hdr_q;
  logic [PCS_DATA_WIDTH-1:0] descr;
  logic                      hdr_ok;

  assign hdr_ok = sh_valid(bus.in_block_header);

  rx_descrambler_58 u_descr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (bus.in_block_valid),
    .data_i (bus.in_block_data),
    .data_o (descr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LK_HUNT;
      sh_cnt_q   <= '0;
      win_cnt_q  <= '0;
      bad_cnt_q  <= '0;
      wait_cnt_q <= '0;
      slip_q     <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      slip_q <= 1'b0;
      if (bus.in_block_valid) begin
        unique case (state_q)
          LK_HUNT: begin
            // A bad header on the final hunt block still slips rather than locks
            if (!hdr_ok) begin
              slip_q     <= 1'b1;
              sh_cnt_q   <= '0;
              wait_cnt_q <= '0;
              state_q    <= LK_SLIP_WAIT;
            end else if (sh_cnt_q == SH_W'(LOCK_CNT - 1)) begin
              lock_q    <= 1'b1;
              sh_cnt_q  <= '0;
              win_cnt_q <= '0;
              bad_cnt_q <= '0;
              state_q   <= LK_LOCKED;
            end else begin
              sh_cnt_q <= sh_cnt_q + SH_W'(1);
            end
          end
          LK_SLIP_WAIT: begin
            if (wait_cnt_q == WT_W'(SLIP_WAIT - 1)) begin
              wait_cnt_q <= '0;
              state_q    <= LK_HUNT;
            end else begin
              wait_cnt_q <= wait_cnt_q + WT_W'(1);
            end
          end
          LK_LOCKED: begin
            if (!hdr_ok && (bad_cnt_q == BD_W'(BAD_SH_MAX - 1))) begin
              slip_q     <= 1'b1;
              lock_q     <= 1'b0;
              win_cnt_q  <= '0;
              bad_cnt_q  <= '0;
              wait_cnt_q <= '0;
              state_q    <= LK_SLIP_WAIT;
            end else if (win_cnt_q == WN_W'(WINDOW_CNT - 1)) begin
              win_cnt_q <= '0;
              bad_cnt_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + WN_W'(1);
              if (!hdr_ok) begin
                bad_cnt_q <= bad_cnt_q + BD_W'(1);
              end
            end
          end
          default: state_q <= LK_HUNT;
        endcase
      end
    end
  end

  // Output stage: the block that loses lock is still forwarded (lock_q is pre-update)
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_hdr_q  <= 2'b00;
    end else begin
      out_vld_q <= bus.in_block_valid & lock_q & (state_q != LK_SLIP_WAIT);
      if (bus.in_block_valid) begin
        out_data_q <= descr;
        out_hdr_q  <= bus.in_block_header;
      end
    end
  end

  assign bus.out_slip           = slip_q;
  assign bus.out_block_lock     = lock_q;
  assign bus.out_encoded_valid  = out_vld_q;
  assign bus.out_encoded_data   = out_data_q;
  assign bus.out_encoded_header = out_hdr_q;

endmodule

// File: tb/tb_rx_block_lock_descrambler.sv
// Scoreboard bench for rx_block_lock_descrambler: directed lock/slip/reset/gap
// scenarios plus a reference-scrambled idle stream.
module tb_rx_block_lock_descrambler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_block_lock_descrambler_if #(.PCS_DATA_WIDTH(64)) bus ();

  rx_block_lock_descrambler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [63:0] IMPULSE     = 64'h0000_0000_0000_0001;
  localparam logic [63:0] IMPULSE_OUT = 64'h0400_0080_0000_0001;
  localparam logic [63:0] IDLE        = 64'h0000_0000_0000_001E;

  int          n_tests  = 0;
  int          n_fail   = 0;
  int          slip_cnt = 0;
  logic [65:0] exp_q[$];
  logic [57:0] scr_state;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [65:0] e;
    if (bus.out_slip) slip_cnt++;
    if (bus.out_encoded_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got %h, expected no block",
                 {bus.out_encoded_header, bus.out_encoded_data});
      end else begin
        e = exp_q.pop_front();
        chk("sb_block", {bus.out_encoded_header, bus.out_encoded_data}, e);
      end
    end
  end

  task automatic send(input logic [1:0] h, input logic [63:0] d, input bit exp, input logic [63:0] ed);
    @(negedge clk);
    bus.in_block_valid  = 1'b1;
    bus.in_block_header = h;
    bus.in_block_data   = d;
    if (exp) exp_q.push_back({h, ed});
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_block_valid = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_block_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic scramble(input logic [63:0] d, output logic [63:0] s);
    logic [121:0] e;
    e = '0;
    e[57:0] = scr_state;
    for (int i = 0; i < 64; i++) e[58+i] = d[i] ^ e[19+i] ^ e[i];
    s = e[121:58];
    scr_state = e[121:64];
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] s;
    int          slip_before;
    bus.in_block_valid  = 1'b0;
    bus.in_block_header = 2'b00;
    bus.in_block_data   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lock",  66'(bus.out_block_lock),    66'd0);
    chk("rst_valid", 66'(bus.out_encoded_valid), 66'd0);
    chk("rst_slip",  66'(bus.out_slip),          66'd0);
    chk("rst_data",  {bus.out_encoded_header, bus.out_encoded_data}, 66'd0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: 64 good headers -> lock
    for (int k = 1; k <= 64; k++) begin
      send(2'b01, '0, 1'b0, '0);
      if (k == 63) begin settle(); chk("t1_lock_63", 66'(bus.out_block_lock), 66'd0); end
    end
    settle();
    chk("t1_lock_64",  66'(bus.out_block_lock),    66'd1);
    chk("t1_valid_64", 66'(bus.out_encoded_valid), 66'd0);
    send(2'b01, '0, 1'b1, '0);
    settle();
    chk("t1_first_valid", 66'(bus.out_encoded_valid), 66'd1);
    send(2'b10, '0, 1'b1, '0);
    send(2'b01, '0, 1'b1, '0);
    chk("t1_no_slip", 66'(slip_cnt), 66'd0);

    // Test 3: window accounting (3 blocks of window already used)
    for (int k = 0; k < 61; k++) send(2'b01, '0, 1'b1, '0);
    send(2'b01, IMPULSE, 1'b1, IMPULSE_OUT);
    send(2'b10, '0, 1'b1, '0);
    for (int k = 0; k < 47; k++) send(2'b01, '0, 1'b1, '0);
    for (int k = 0; k < 15; k++) send(((k % 2) != 0) ? 2'b11 : 2'b00, '0, 1'b1, '0);
    for (int k = 0; k < 15; k++) send(2'b00, '0, 1'b1, '0);
    for (int k = 0; k < 49; k++) send(2'b10, '0, 1'b1, '0);
    settle();
    chk("t3_15bad_lock", 66'(bus.out_block_lock), 66'd1);
    chk("t3_15bad_noslip", 66'(slip_cnt), 66'd0);
    for (int k = 0; k < 15; k++) send(2'b11, '0, 1'b1, '0);
    settle();
    chk("t3_15th_lock", 66'(bus.out_block_lock), 66'd1);
    send(2'b00, '0, 1'b1, '0);
    settle();
    chk("t3_16th_lock", 66'(bus.out_block_lock), 66'd0);
    chk("t3_16th_slip", 66'(bus.out_slip),       66'd1);

    // Test 2: slip wait ignores headers, then a mid-hunt slip restarts the count
    send(2'b00, '0, 1'b0, '0);
    settle();
    chk("t2_slip_pulse_end", 66'(bus.out_slip), 66'd0);
    for (int k = 0; k < 3; k++) send(2'b00, '0, 1'b0, '0);
    for (int k = 0; k < 9; k++) send(2'b01, '0, 1'b0, '0);
    chk("t2_wait_no_slip", 66'(slip_cnt), 66'd1);
    send(2'b00, '0, 1'b0, '0);
    settle();
    chk("t2_slip", 66'(bus.out_slip), 66'd1);
    for (int k = 0; k < 4; k++) send(2'b11, '0, 1'b0, '0);
    for (int k = 1; k <= 64; k++) begin
      send(2'b10, '0, 1'b0, '0);
      if (k == 63) begin settle(); chk("t2_lock_63", 66'(bus.out_block_lock), 66'd0); end
    end
    settle();
    chk("t2_lock_64", 66'(bus.out_block_lock), 66'd1);
    chk("t2_slip_total", 66'(slip_cnt), 66'd2);

    // Test 5: reset while locked
    send(2'b01, IMPULSE, 1'b1, IMPULSE_OUT);
    @(negedge clk);
    rst = 1'b1;
    bus.in_block_header = 2'b01;
    bus.in_block_data   = '0;
    settle();
    chk("t5_lock",  66'(bus.out_block_lock),    66'd0);
    chk("t5_valid", 66'(bus.out_encoded_valid), 66'd0);
    chk("t5_data",  {bus.out_encoded_header, bus.out_encoded_data}, 66'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_block_valid = 1'b0;
    slip_before = slip_cnt;
    for (int k = 1; k <= 64; k++) begin
      send(2'b01, '0, 1'b0, '0);
      if (k == 63) begin settle(); chk("t5_relock_63", 66'(bus.out_block_lock), 66'd0); end
    end
    settle();
    chk("t5_relock_64", 66'(bus.out_block_lock), 66'd1);
    chk("t5_no_slip", 66'(slip_cnt - slip_before), 66'd0);

    // Test 6: valid one cycle in three
    pulse_reset();
    for (int k = 1; k <= 64; k++) begin
      send(2'b01, '0, 1'b0, '0);
      if (k == 63) begin settle(); chk("t6_lock_63", 66'(bus.out_block_lock), 66'd0); end
      if (k == 64) begin settle(); chk("t6_lock_64", 66'(bus.out_block_lock), 66'd1); end
      idle();
      idle();
    end
    for (int k = 0; k < 2; k++) begin
      send(2'b10, '0, 1'b1, '0);
      settle();
      chk("t6_latency_vld", 66'(bus.out_encoded_valid), 66'd1);
      idle();
      settle();
      chk("t6_gap_vld", 66'(bus.out_encoded_valid), 66'd0);
    end

    // Test 4: reference-scrambled idle stream
    pulse_reset();
    scr_state = 58'h3FF_FFFF_FFFF_FFFF;
    for (int k = 1; k <= 70; k++) begin
      scramble(IDLE, s);
      send(2'b10, s, k > 64, IDLE);
    end
    idle();
    repeat (3) @(negedge clk);
    chk("sb_drained", 66'(exp_q.size()), 66'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
